// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: scan counters, active-video flag and active-low syncs.
// Optional macro VGA_TIMING_PRESCALE_EN adds an internal divide-by-4 pixel tick.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       valid,
  output logic       hsync,
  output logic       vsync,
  output logic       pixel_tick,
  output logic       frame_start
);
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  logic       tick;
  logic [9:0] h_next;
  logic [9:0] v_next;
  logic       valid_next;
  logic       hsync_next;
  logic       vsync_next;

`ifdef VGA_TIMING_PRESCALE_EN
  logic [1:0] prescale;

  always_ff @(posedge clk) begin
    if (rst) prescale <= 2'd0;
    else     prescale <= prescale + 2'd1;
  end

  assign tick = (prescale == 2'd3);
`else
  assign tick = 1'b1;
`endif

  // Raster position after the next tick; outputs are decoded from it so
  // every registered output describes the same pixel.
  always_comb begin
    h_next = h_cnt + 10'd1;
    v_next = v_cnt;
    if (h_cnt == H_LAST) begin
      h_next = 10'd0;
      v_next = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end
  end

  always_comb begin
    valid_next = (int'(h_next) < H_VISIBLE) && (int'(v_next) < V_VISIBLE);
    hsync_next = !((int'(h_next) >= H_VISIBLE + H_FP) &&
                   (int'(h_next) <  H_VISIBLE + H_FP + H_SYNC));
    vsync_next = !((int'(v_next) >= V_VISIBLE + V_FP) &&
                   (int'(v_next) <  V_VISIBLE + V_FP + V_SYNC));
  end

  // Reset parks the raster on the last pixel so the first tick lands on (0,0).
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt       <= H_LAST;
      v_cnt       <= V_LAST;
      valid       <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      pixel_tick  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pixel_tick  <= tick;
      frame_start <= tick && (h_next == 10'd0) && (v_next == 10'd0);
      if (tick) begin
        h_cnt <= h_next;
        v_cnt <= v_next;
        valid <= valid_next;
        hsync <= hsync_next;
        vsync <= vsync_next;
      end
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: full-size instance for line timing,
// reduced-size instance for frame wrap, sync counts and mid-frame reset.
module tb_vga_timing_gen;
`ifdef VGA_TIMING_PRESCALE_EN
  localparam int TP = 4;
`else
  localparam int TP = 1;
`endif
  // reduced raster: 16 x 8, hsync low at h 10..12, vsync low at v 5..6
  localparam int SH = 16;
  localparam int SV = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [9:0] h_cnt, v_cnt, s_h, s_v;
  logic valid, hsync, vsync, pixel_tick, frame_start;
  logic s_valid, s_hsync, s_vsync, s_tick, s_fs;

  vga_timing_gen dut (
    .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .valid(valid),
    .hsync(hsync), .vsync(vsync), .pixel_tick(pixel_tick), .frame_start(frame_start)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_s (
    .clk(clk), .rst(rst), .h_cnt(s_h), .v_cnt(s_v), .valid(s_valid),
    .hsync(s_hsync), .vsync(s_vsync), .pixel_tick(s_tick), .frame_start(s_fs)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_big(input string tag);
    chk({tag, " h_cnt"}, 32'(h_cnt), 799);
    chk({tag, " v_cnt"}, 32'(v_cnt), 524);
    chk({tag, " valid"}, 32'(valid), 0);
    chk({tag, " hsync"}, 32'(hsync), 1);
    chk({tag, " vsync"}, 32'(vsync), 1);
    chk({tag, " pixel_tick"}, 32'(pixel_tick), 0);
    chk({tag, " frame_start"}, 32'(frame_start), 0);
  endtask

  task automatic chk_reset_small(input string tag);
    chk({tag, " small h_cnt"}, 32'(s_h), SH - 1);
    chk({tag, " small v_cnt"}, 32'(s_v), SV - 1);
    chk({tag, " small flags"}, 32'({s_valid, s_hsync, s_vsync, s_tick, s_fs}), 32'b01100);
  endtask

  typedef struct {
    int t;
    int h;
    int v;
    bit vld;
    bit hs;
    bit vs;
    bit fs;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int prev;
    int cnt;
    int last_fs;
    int vs_low;
    int hs_low;
    int n;
    int t;
    int eh;
    int ev;
    logic [24:0] act_v;
    logic [24:0] exp_v;

    // ticks since the first (0,0); position = (t % 800, t / 800)
    tbl[0]  = '{0,    0,   0,  1, 1, 1, 1};
    tbl[1]  = '{1,    1,   0,  1, 1, 1, 0};
    tbl[2]  = '{639,  639, 0,  1, 1, 1, 0};
    tbl[3]  = '{640,  640, 0,  0, 1, 1, 0};
    tbl[4]  = '{655,  655, 0,  0, 1, 1, 0};
    tbl[5]  = '{656,  656, 0,  0, 0, 1, 0};
    tbl[6]  = '{751,  751, 0,  0, 0, 1, 0};
    tbl[7]  = '{752,  752, 0,  0, 1, 1, 0};
    tbl[8]  = '{799,  799, 0,  0, 1, 1, 0};
    tbl[9]  = '{800,  0,   1,  1, 1, 1, 0};
    tbl[10] = '{8799, 799, 10, 0, 1, 1, 0};
    tbl[11] = '{8800, 0,   11, 1, 1, 1, 0};
    tbl[12] = '{9440, 640, 11, 0, 1, 1, 0};

    // reset state
    rst = 1'b1;
    clks(3);
    chk_reset_big("reset");
    chk_reset_small("reset");

    // release: (0,0) appears TP clocks later, reset values before that
    rst = 1'b0;
    if (TP > 1) begin
      clks(TP - 1);
      chk("pre-tick h_cnt", 32'(h_cnt), 799);
      clks(1);
    end else begin
      clks(1);
    end
    prev = 0;

    foreach (tbl[i]) begin
      clks((tbl[i].t - prev) * TP);
      prev = tbl[i].t;
      chk($sformatf("vec%0d h_cnt", i), 32'(h_cnt), 32'(tbl[i].h));
      chk($sformatf("vec%0d v_cnt", i), 32'(v_cnt), 32'(tbl[i].v));
      chk($sformatf("vec%0d valid", i), 32'(valid), 32'(tbl[i].vld));
      chk($sformatf("vec%0d hsync", i), 32'(hsync), 32'(tbl[i].hs));
      chk($sformatf("vec%0d vsync", i), 32'(vsync), 32'(tbl[i].vs));
      chk($sformatf("vec%0d frame_start", i), 32'(frame_start), 32'(tbl[i].fs));
      chk($sformatf("vec%0d pixel_tick", i), 32'(pixel_tick), 1);
    end

    // hold between ticks, then one full line: period and hsync-low count
    if (TP > 1) begin
      clks(1);
      chk("hold pixel_tick", 32'(pixel_tick), 0);
      chk("hold h_cnt", 32'(h_cnt), 640);
      clks(160 * TP - 1);
    end else begin
      clks(160);
    end
    chk("line start h_cnt", 32'(h_cnt), 0);
    chk("line start v_cnt", 32'(v_cnt), 12);
    hs_low = 0;
    for (int c = 0; c < 800 * TP; c++) begin
      if (hsync == 1'b0) hs_low++;
      clks(1);
    end
    chk("line period h_cnt", 32'(h_cnt), 0);
    chk("line period v_cnt", 32'(v_cnt), 13);
    chk("hsync low clk per line", 32'(hs_low), 96 * TP);

    // reduced raster: cycle-by-cycle against a modulo model
    rst = 1'b1;
    clks(3);
    rst = 1'b0;
    last_fs = -1;
    vs_low = 0;
    hs_low = 0;
    for (int c = 1; c <= 331 * TP; c++) begin
      clks(1);
      n = c / TP;
      if (n == 0) begin
        exp_v = {10'(SH - 1), 10'(SV - 1), 5'b01100};
      end else begin
        t  = n - 1;
        eh = t % SH;
        ev = (t / SH) % SV;
        exp_v = {10'(eh), 10'(ev),
                 (eh < 8) && (ev < 4),
                 !((eh >= 10) && (eh < 13)),
                 !((ev >= 5) && (ev < 7)),
                 (c % TP) == 0,
                 ((c % TP) == 0) && ((t % (SH * SV)) == 0)};
      end
      act_v = {s_h, s_v, s_valid, s_hsync, s_vsync, s_tick, s_fs};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL small raster c=%0d: got h=%0d v=%0d flags=%b expected h=%0d v=%0d flags=%b",
                 c, act_v[24:15], act_v[14:5], act_v[4:0], exp_v[24:15], exp_v[14:5], exp_v[4:0]);
      end
      if (s_fs) begin
        if (last_fs >= 0) begin
          chk("frame_start gap", 32'(c - last_fs), SH * SV * TP);
          chk("vsync low clk per frame", 32'(vs_low), 2 * SH * TP);
          chk("hsync low clk per frame", 32'(hs_low), 3 * SV * TP);
        end
        last_fs = c;
        vs_low = 0;
        hs_low = 0;
      end
      if (!s_vsync) vs_low++;
      if (!s_hsync) hs_low++;
    end
    chk("frame_start seen", 32'(last_fs > 0), 1);

    // mid-frame reset while hsync is low, prescaler phase 2
    clks(2);
    chk("pre-reset small hsync", 32'(s_hsync), 0);
    rst = 1'b1;
    clks(1);
    chk_reset_small("midreset");
    chk_reset_big("midreset");
    rst = 1'b0;
    if (TP > 1) begin
      clks(TP - 1);
      chk_reset_small("restart pre-tick");
    end
    clks(1);
    chk("restart h_cnt", 32'(h_cnt), 0);
    chk("restart v_cnt", 32'(v_cnt), 0);
    chk("restart valid", 32'(valid), 1);
    chk("restart frame_start", 32'(frame_start), 1);
    chk("restart small pos", 32'({s_h, s_v}), 0);
    clks(1);
    chk("restart frame_start one clk", 32'(frame_start), 0);
    chk("restart next h_cnt", 32'(h_cnt), (TP > 1) ? 0 : 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
